// File: rtl/elbeth_id_exs_stage.sv
// ============================================================================
// Module   : elbeth_id_exs_stage
// Brief    : ID->EXS pipeline register with operand forwarding, load-use
//            bubble insertion, external stall and flush.
//            Optional macro ELBETH_PERF_CNT_EN adds output bubble_count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module elbeth_id_exs_stage #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_in,
  input  logic                flush,
  input  logic                id_valid,
  input  logic [XLEN-1:0]     id_pc,
  input  logic [4:0]          id_rs1,
  input  logic [4:0]          id_rs2,
  input  logic [XLEN-1:0]     id_rs1_data,
  input  logic [XLEN-1:0]     id_rs2_data,
  input  logic [4:0]          id_rd_addr,
  input  logic                id_w_gpr_en,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic [XLEN-1:0]     id_imm,
  input  logic                match_forward_rs1,
  input  logic                match_forward_rs2,
  input  logic [XLEN-1:0]     exs_fwd_data,
  input  logic [XLEN-1:0]     mem_load_data,
  output logic                id_stall,
  output logic                exs_valid,
  output logic [XLEN-1:0]     exs_pc,
  output logic [XLEN-1:0]     exs_rs1_data,
  output logic [XLEN-1:0]     exs_rs2_data,
  output logic [4:0]          exs_rd_addr,
  output logic                exs_w_gpr_en,
  output logic                exs_mem_read,
  output logic                exs_mem_write,
  output logic [ALU_OP_W-1:0] exs_alu_op,
  output logic [XLEN-1:0]     exs_imm
`ifdef ELBETH_PERF_CNT_EN
  ,
  output logic [31:0]         bubble_count
`endif
);

  localparam logic [0:0] S_RUN    = 1'b0;
  localparam logic [0:0] S_BUBBLE = 1'b1;

  logic [0:0]          r_state;
  logic [0:0]          w_state_next;
  logic [4:0]          r_load_rd;

  logic                r_exs_valid;
  logic [XLEN-1:0]     r_exs_pc;
  logic [XLEN-1:0]     r_exs_rs1_data;
  logic [XLEN-1:0]     r_exs_rs2_data;
  logic [4:0]          r_exs_rd_addr;
  logic                r_exs_w_gpr_en;
  logic                r_exs_mem_read;
  logic                r_exs_mem_write;
  logic [ALU_OP_W-1:0] r_exs_alu_op;
  logic [XLEN-1:0]     r_exs_imm;

  logic                w_load_use;
  logic                w_bubble_ins;
  logic                w_capture;
  logic                w_id_stall;
  logic [XLEN-1:0]     w_rs1_res;
  logic [XLEN-1:0]     w_rs2_res;

  assign w_load_use = id_valid & r_exs_valid & r_exs_mem_read & r_exs_w_gpr_en &
                      (r_exs_rd_addr != 5'd0) &
                      ((r_exs_rd_addr == id_rs1) | (r_exs_rd_addr == id_rs2));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = S_RUN;
    end else if (!stall_in) begin
      case (r_state)
        S_RUN:    w_state_next = w_load_use ? S_BUBBLE : S_RUN;
        S_BUBBLE: w_state_next = S_RUN;
        default:  w_state_next = S_RUN;
      endcase
    end
  end

  // Output / action decode; id_stall is held low while reset is asserted
  always_comb begin
    w_id_stall   = 1'b0;
    w_bubble_ins = 1'b0;
    w_capture    = 1'b0;
    w_id_stall   = rst_n & (stall_in | ((r_state == S_RUN) & w_load_use));
    w_bubble_ins = ~flush & ~stall_in & (r_state == S_RUN) & w_load_use;
    w_capture    = ~flush & ~stall_in & ~w_bubble_ins;
  end

  // In BUBBLE the EXS slot is empty, so the forward matches are stale and the
  // only possible late operand is the load that caused the bubble.
  always_comb begin
    w_rs1_res = id_rs1_data;
    w_rs2_res = id_rs2_data;
    if (r_state == S_BUBBLE) begin
      if ((id_rs1 == r_load_rd) && (r_load_rd != 5'd0)) w_rs1_res = mem_load_data;
      if ((id_rs2 == r_load_rd) && (r_load_rd != 5'd0)) w_rs2_res = mem_load_data;
    end else begin
      if (match_forward_rs1) w_rs1_res = exs_fwd_data;
      if (match_forward_rs2) w_rs2_res = exs_fwd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exs_valid     <= 1'b0;
      r_exs_pc        <= '0;
      r_exs_rs1_data  <= '0;
      r_exs_rs2_data  <= '0;
      r_exs_rd_addr   <= 5'd0;
      r_exs_w_gpr_en  <= 1'b0;
      r_exs_mem_read  <= 1'b0;
      r_exs_mem_write <= 1'b0;
      r_exs_alu_op    <= '0;
      r_exs_imm       <= '0;
      r_load_rd       <= 5'd0;
    end else if (flush) begin
      r_exs_valid     <= 1'b0;
      r_exs_w_gpr_en  <= 1'b0;
      r_exs_mem_read  <= 1'b0;
      r_exs_mem_write <= 1'b0;
    end else if (w_bubble_ins) begin
      r_exs_valid     <= 1'b0;
      r_exs_w_gpr_en  <= 1'b0;
      r_exs_mem_read  <= 1'b0;
      r_exs_mem_write <= 1'b0;
      r_load_rd       <= r_exs_rd_addr;
    end else if (w_capture) begin
      r_exs_valid     <= id_valid;
      r_exs_pc        <= id_pc;
      r_exs_rs1_data  <= w_rs1_res;
      r_exs_rs2_data  <= w_rs2_res;
      r_exs_rd_addr   <= id_rd_addr;
      r_exs_w_gpr_en  <= id_w_gpr_en;
      r_exs_mem_read  <= id_mem_read;
      r_exs_mem_write <= id_mem_write;
      r_exs_alu_op    <= id_alu_op;
      r_exs_imm       <= id_imm;
    end
  end

`ifdef ELBETH_PERF_CNT_EN
  logic [31:0] r_bubble_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_count <= 32'd0;
    end else if (w_bubble_ins) begin
      r_bubble_count <= r_bubble_count + 32'd1;
    end
  end

  assign bubble_count = r_bubble_count;
`endif

  assign id_stall      = w_id_stall;
  assign exs_valid     = r_exs_valid;
  assign exs_pc        = r_exs_pc;
  assign exs_rs1_data  = r_exs_rs1_data;
  assign exs_rs2_data  = r_exs_rs2_data;
  assign exs_rd_addr   = r_exs_rd_addr;
  assign exs_w_gpr_en  = r_exs_w_gpr_en;
  assign exs_mem_read  = r_exs_mem_read;
  assign exs_mem_write = r_exs_mem_write;
  assign exs_alu_op    = r_exs_alu_op;
  assign exs_imm       = r_exs_imm;

endmodule

`default_nettype wire

// File: tb/tb_elbeth_id_exs_stage.sv
// ============================================================================
// Module   : tb_elbeth_id_exs_stage
// Brief    : Directed and random bench for elbeth_id_exs_stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_elbeth_id_exs_stage;

  localparam int XLEN     = 32;
  localparam int ALU_OP_W = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                stall_in;
  logic                flush;
  logic                id_valid;
  logic [XLEN-1:0]     id_pc;
  logic [4:0]          id_rs1;
  logic [4:0]          id_rs2;
  logic [XLEN-1:0]     id_rs1_data;
  logic [XLEN-1:0]     id_rs2_data;
  logic [4:0]          id_rd_addr;
  logic                id_w_gpr_en;
  logic                id_mem_read;
  logic                id_mem_write;
  logic [ALU_OP_W-1:0] id_alu_op;
  logic [XLEN-1:0]     id_imm;
  logic                match_forward_rs1;
  logic                match_forward_rs2;
  logic [XLEN-1:0]     exs_fwd_data;
  logic [XLEN-1:0]     mem_load_data;
  logic                id_stall;
  logic                exs_valid;
  logic [XLEN-1:0]     exs_pc;
  logic [XLEN-1:0]     exs_rs1_data;
  logic [XLEN-1:0]     exs_rs2_data;
  logic [4:0]          exs_rd_addr;
  logic                exs_w_gpr_en;
  logic                exs_mem_read;
  logic                exs_mem_write;
  logic [ALU_OP_W-1:0] exs_alu_op;
  logic [XLEN-1:0]     exs_imm;
`ifdef ELBETH_PERF_CNT_EN
  logic [31:0]         bubble_count;
`endif

  elbeth_id_exs_stage #(.XLEN(XLEN), .ALU_OP_W(ALU_OP_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_rd_addr(id_rd_addr), .id_w_gpr_en(id_w_gpr_en),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_alu_op(id_alu_op), .id_imm(id_imm),
    .match_forward_rs1(match_forward_rs1), .match_forward_rs2(match_forward_rs2),
    .exs_fwd_data(exs_fwd_data), .mem_load_data(mem_load_data),
    .id_stall(id_stall), .exs_valid(exs_valid), .exs_pc(exs_pc),
    .exs_rs1_data(exs_rs1_data), .exs_rs2_data(exs_rs2_data),
    .exs_rd_addr(exs_rd_addr), .exs_w_gpr_en(exs_w_gpr_en),
    .exs_mem_read(exs_mem_read), .exs_mem_write(exs_mem_write),
    .exs_alu_op(exs_alu_op), .exs_imm(exs_imm)
`ifdef ELBETH_PERF_CNT_EN
    , .bubble_count(bubble_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what the EXS slot should hold, plus whether the
  // instruction now in ID is the one sitting behind an inserted bubble.
  logic                m_valid, m_we, m_mr, m_mw;
  logic [XLEN-1:0]     m_pc, m_r1, m_r2, m_imm;
  logic [4:0]          m_rd;
  logic [ALU_OP_W-1:0] m_op;
  logic                m_after_bubble;
  logic [4:0]          m_bubble_rd;
  logic [31:0]         m_cnt;
  logic                s_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_we = 0; m_mr = 0; m_mw = 0;
    m_pc = 0; m_r1 = 0; m_r2 = 0; m_imm = 0; m_rd = 0; m_op = 0;
    m_after_bubble = 0; m_bubble_rd = 0; m_cnt = 0;
  endtask

  // Value an ID source register should carry into EXS.
  function automatic logic [XLEN-1:0] src_value(input logic [4:0] rs,
                                                 input logic [XLEN-1:0] rf,
                                                 input logic fwd);
    if (m_after_bubble)
      return (rs != 0 && rs == m_bubble_rd) ? mem_load_data : rf;
    return fwd ? exs_fwd_data : rf;
  endfunction

  function automatic logic hazard();
    // ID consumes the result of a load that is only now entering EXS
    return id_valid && m_valid && m_mr && m_we && m_rd != 0 &&
           (m_rd == id_rs1 || m_rd == id_rs2);
  endfunction

  task automatic model_edge();
    logic needs_bubble;
    needs_bubble = !m_after_bubble && hazard();
    if (flush) begin
      m_valid = 0; m_we = 0; m_mr = 0; m_mw = 0;
      m_after_bubble = 0;
    end else if (stall_in) begin
      // nothing moves
    end else if (needs_bubble) begin
      m_valid = 0; m_we = 0; m_mr = 0; m_mw = 0;
      m_bubble_rd = m_rd;
      m_after_bubble = 1;
      m_cnt = m_cnt + 1;
    end else begin
      m_r1 = src_value(id_rs1, id_rs1_data, match_forward_rs1);
      m_r2 = src_value(id_rs2, id_rs2_data, match_forward_rs2);
      m_valid = id_valid; m_pc = id_pc; m_rd = id_rd_addr;
      m_we = id_w_gpr_en; m_mr = id_mem_read; m_mw = id_mem_write;
      m_op = id_alu_op; m_imm = id_imm;
      m_after_bubble = 0;
    end
  endtask

  task automatic check_outs();
    chk("exs_valid", exs_valid, m_valid);
    chk("exs_w_gpr_en", exs_w_gpr_en, m_we);
    chk("exs_mem_read", exs_mem_read, m_mr);
    chk("exs_mem_write", exs_mem_write, m_mw);
    if (m_valid) begin
      chk("exs_pc", exs_pc, m_pc);
      chk("exs_rs1_data", exs_rs1_data, m_r1);
      chk("exs_rs2_data", exs_rs2_data, m_r2);
      chk("exs_rd_addr", exs_rd_addr, m_rd);
      chk("exs_alu_op", exs_alu_op, m_op);
      chk("exs_imm", exs_imm, m_imm);
    end
`ifdef ELBETH_PERF_CNT_EN
    chk("bubble_count", bubble_count, m_cnt);
`endif
  endtask

  // One clock: check the combinational stall, advance the model, clock, check.
  task automatic cyc();
    logic exp_stall;
    #1;
    exp_stall = stall_in || (!m_after_bubble && hazard());
    s_stall = id_stall;
    chk("id_stall", s_stall, exp_stall);
    model_edge();
    @(posedge clk);
    #1;
    check_outs();
  endtask

  task automatic id_clear();
    stall_in = 0; flush = 0; id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_rd_addr = 0; id_w_gpr_en = 0;
    id_mem_read = 0; id_mem_write = 0; id_alu_op = 0; id_imm = 0;
    match_forward_rs1 = 0; match_forward_rs2 = 0; exs_fwd_data = 0; mem_load_data = 0;
  endtask

  task automatic id_instr(input logic [4:0] rd, input logic we, input logic mr,
                          input logic [4:0] rs1, input logic [4:0] rs2);
    id_valid = 1; id_pc = id_pc + 4; id_rd_addr = rd; id_w_gpr_en = we;
    id_mem_read = mr; id_mem_write = 0; id_rs1 = rs1; id_rs2 = rs2;
    id_alu_op = 4'h3; id_imm = 32'h100 + {27'd0, rd};
    id_rs1_data = 32'h1000 + {27'd0, rs1}; id_rs2_data = 32'h2000 + {27'd0, rs2};
  endtask

  initial begin
    logic [31:0] cnt_before;
    id_clear();
    model_reset();
    rst_n = 0;
    stall_in = 1;
    #2;
    chk("rst_id_stall", id_stall, 0);
    check_outs();
    chk("rst_exs_pc", exs_pc, 0);
    chk("rst_exs_rd", exs_rd_addr, 0);
    chk("rst_exs_imm", exs_imm, 0);
    #1;
    stall_in = 0;
    rst_n = 1;

    // Forwarding from EXS into rs1
    id_instr(5'd5, 1, 0, 5'd1, 5'd2);
    cyc();
    id_instr(5'd6, 1, 0, 5'd5, 5'd6);
    match_forward_rs1 = 1; exs_fwd_data = 32'hAA;
    id_rs1_data = 32'h11; id_rs2_data = 32'h22;
    cyc();
    chk("fwd_rs1", exs_rs1_data, 32'hAA);
    chk("fwd_rs2", exs_rs2_data, 32'h22);
    match_forward_rs1 = 0;

    // Load-use on x7
    id_instr(5'd7, 1, 1, 5'd1, 5'd2);
    cyc();
    id_instr(5'd8, 1, 0, 5'd1, 5'd7);
    cyc();
    chk("lu_stall", s_stall, 1);
    chk("lu_bubble", exs_valid, 0);
    mem_load_data = 32'hDEADBEEF;
    cyc();
    chk("lu_stall_after", s_stall, 0);
    chk("lu_rs2_load", exs_rs2_data, 32'hDEADBEEF);
    chk("lu_valid", exs_valid, 1);

    // Load to x0 never stalls
    id_instr(5'd0, 1, 1, 5'd1, 5'd2);
    cyc();
    id_instr(5'd3, 1, 0, 5'd0, 5'd4);
    cyc();
    chk("x0_no_stall", s_stall, 0);
    chk("x0_valid", exs_valid, 1);

    // Flush and stall_in together while a load-use is pending
    id_instr(5'd7, 1, 1, 5'd1, 5'd2);
    cyc();
    id_instr(5'd9, 1, 0, 5'd7, 5'd2);
    flush = 1; stall_in = 1;
    cyc();
    chk("flush_valid", exs_valid, 0);
    flush = 0; stall_in = 0;
    cyc();
    chk("flush_run_capture", exs_valid, 1);

    // stall_in held three cycles while in BUBBLE
    id_instr(5'd9, 1, 1, 5'd1, 5'd2);
    cyc();
    cnt_before = m_cnt;
    id_instr(5'd10, 1, 0, 5'd9, 5'd3);
    cyc();
    chk("sb_bubble", exs_valid, 0);
    mem_load_data = 32'h12345678;
    stall_in = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("sb_frozen", exs_valid, 0);
    end
    stall_in = 0;
    cyc();
    chk("sb_rs1_load", exs_rs1_data, 32'h12345678);
    chk("sb_valid", exs_valid, 1);
    chk("sb_count_delta", m_cnt - cnt_before, 1);
`ifdef ELBETH_PERF_CNT_EN
    chk("sb_bubble_count", bubble_count - cnt_before, 1);
`endif

    // Asynchronous reset mid-operation
    rst_n = 0;
    stall_in = 1;
    #1;
    chk("arst_valid", exs_valid, 0);
    chk("arst_pc", exs_pc, 0);
    chk("arst_rs1", exs_rs1_data, 0);
    chk("arst_id_stall", id_stall, 0);
    model_reset();
    check_outs();
    #3;
    rst_n = 1;
    stall_in = 0;

    // Random traffic; a narrow register range makes hazards frequent
    for (int n = 0; n < 600; n++) begin
      stall_in          = ($urandom_range(0, 7) == 0);
      flush             = ($urandom_range(0, 15) == 0);
      id_valid          = ($urandom_range(0, 7) != 0);
      id_pc             = $urandom;
      id_rs1            = 5'($urandom_range(0, 3));
      id_rs2            = 5'($urandom_range(0, 3));
      id_rs1_data       = $urandom;
      id_rs2_data       = $urandom;
      id_rd_addr        = 5'($urandom_range(0, 3));
      id_w_gpr_en       = ($urandom_range(0, 3) != 0);
      id_mem_read       = $urandom_range(0, 1) == 1;
      id_mem_write      = $urandom_range(0, 1) == 1;
      id_alu_op         = 4'($urandom);
      id_imm            = $urandom;
      match_forward_rs1 = ($urandom_range(0, 3) == 0);
      match_forward_rs2 = ($urandom_range(0, 3) == 0);
      exs_fwd_data      = $urandom;
      mem_load_data     = $urandom;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
